mem_ctrl_fsm: RTL and testbench
===============================

Name: mem_ctrl_fsm

Overview:
- Parametrised single-port memory with a request/response handshake, FSM-sequenced accesses and a configurable read latency.
- Successor to the fixed 8x8 enable/rb_w memory; adds generic width and depth, backpressure on both sides, and per-word "written" tracking that flags reads of uninitialised words.
- Sits between a requesting master (CPU/DMA stub) and local storage.

Parameters:
- DATA_W, 8, data word width in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W words.
- READ_LAT, 2, cycles from read acceptance to rsp_valid; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  global gate; when low, no new request is accepted.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_rb_w  in  1  operation: 0 = read, 1 = write.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  master accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for write responses.
- rsp_err  out  1  read hit a word not written since reset.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: applies at a clk edge while rst_n=0 and overrides everything. Resulting state: FSM=IDLE; req_ready=0 during reset; rsp_valid=0; rsp_rdata=0; rsp_err=0; busy=0; all written bits cleared. Storage contents are not cleared.
- Reset mid-operation: an in-flight read or pending response is dropped with no rsp_valid. A write already accepted before reset stays in storage, but its written bit is cleared.
- req_ready = (state==IDLE) & enable & rst_n. Combinational, no dependence on req_valid.
- Accept occurs when req_valid & req_ready at a clk edge, on edge N.
- Write accept:
  - Storage[addr] <= wdata and written[addr] <= 1 at edge N.
  - Next state RESP; rsp_valid=1 after edge N with rsp_rdata=0, rsp_err=0.
- Read accept:
  - Capture addr; latency counter <= READ_LAT-1.
  - If READ_LAT==1, next state RESP, else READ_WAIT.
- READ_WAIT: counter decrements each edge. When counter==1, next state RESP.
- RESP entered from a read: rsp_rdata = storage[addr] and rsp_err = ~written[addr], registered on the entering edge. rsp_valid therefore rises exactly READ_LAT edges after accept.
- RESP hold: while rsp_ready=0, rsp_valid/rsp_rdata/rsp_err hold stable.
- RESP exit: on an edge with rsp_ready=1, rsp_valid <= 0, rsp_rdata/rsp_err <= 0, next state IDLE. There is no same-edge re-accept, so max throughput is one op per READ_LAT+1 cycles for reads and 2 cycles for writes.
- rsp_ready already high on RESP entry: the response is still visible for exactly one cycle.
- enable low:
  - In IDLE: blocks acceptance only.
  - In READ_WAIT/RESP: the operation completes normally.
- busy = (state != IDLE).
- Address range: all 2**ADDR_W addresses are valid; there is no out-of-range case.
- Read-after-write to the same address returns the new data, since the write commits before any later read is accepted.
- FSM states: IDLE, READ_WAIT, RESP. Transitions only as listed above; any illegal state encoding goes to IDLE.

Decomposition:
- Package mem_ctrl_pkg holds:
  - state enum (IDLE, READ_WAIT, RESP);
  - op constants OP_READ=1'b0 and OP_WRITE=1'b1;
  - latency counter width function clog2(READ_LAT+1).
- One sub-module, mem_array_sp: DATA_W x 2**ADDR_W storage, synchronous write, asynchronous read, no reset.
- The written bit vector and FSM live in mem_ctrl_fsm.

Test Plan:
- Basic write/read (DATA_W=8, ADDR_W=3, READ_LAT=2): write 0xAB to addr 7 → rsp_valid 1 cycle after accept, rsp_err=0. Then read addr 7 → rsp_valid exactly 2 edges after accept, rsp_rdata=0xAB, rsp_err=0.
- Uninitialised read: after reset, read addr 4 → rsp_err=1. Write 0x5C to addr 4, read again → 0x5C, rsp_err=0.
- Backpressure: hold rsp_ready=0 for 5 cycles on a read of 0xAB → rsp_valid/rsp_rdata stable, req_ready=0 throughout; rsp_ready=1 → IDLE next edge, req_ready=1.
- enable gating: enable=0 with req_valid=1 write 0xFF to addr 0 → no accept, busy=0. Then raise enable → accept; read addr 0 returns 0xFF.
- Mid-op reset: accept read of addr 7, assert rst_n=0 one edge later → no rsp_valid, busy=0. After release, read addr 7 → rsp_err=1.
- Latency sweep: READ_LAT=1 and 15 → rsp_valid exactly READ_LAT edges after accept. Back-to-back reads achieve one op per READ_LAT+1 cycles.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the single-port memory controller: FSM state codes,
// operation encoding and the read-latency counter width helper.
package mem_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t READ_WAIT = 2'd1;
    localparam state_t RESP      = 2'd2;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    // Counter must hold READ_LAT-1 (and stay at least one bit wide).
    function automatic int unsigned lat_cnt_w(input int unsigned read_lat);
        return $clog2(read_lat + 1);
    endfunction

endpackage

// File: rtl/mem_array_sp.sv
// Single-port word storage: synchronous write, asynchronous read, no reset.
module mem_array_sp #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_ctrl_fsm.sv
// Request/response memory controller with configurable read latency and
// per-word written tracking that flags reads of words not written since reset.
module mem_ctrl_fsm
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned READ_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rb_w,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = lat_cnt_w(READ_LAT);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DEPTH-1:0]  written_q, written_d;

    logic              accept;
    logic              mem_we;
    logic              load_rsp;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    assign req_ready = (state_q == IDLE) & enable & rst_n;
    assign accept    = req_valid & req_ready;
    assign mem_we    = accept & (req_rb_w == OP_WRITE);
    // With READ_LAT==1 the response is loaded on the accept edge, before addr_q exists.
    assign rd_addr   = (state_q == IDLE) ? req_addr : addr_q;

    mem_array_sp #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (req_addr),
        .wdata_i (req_wdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        written_d   = written_q;
        load_rsp    = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_rb_w == OP_WRITE) begin
                        written_d[req_addr] = 1'b1;
                        state_d             = RESP;
                        rsp_valid_d         = 1'b1;
                        rsp_rdata_d         = '0;
                        rsp_err_d           = 1'b0;
                    end else begin
                        addr_d = req_addr;
                        cnt_d  = CNT_W'(READ_LAT - 1);
                        if (READ_LAT == 1) begin
                            state_d  = RESP;
                            load_rsp = 1'b1;
                        end else begin
                            state_d = READ_WAIT;
                        end
                    end
                end
            end
            READ_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = RESP;
                    load_rsp = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
            end
        endcase

        if (load_rsp) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rd_data;
            rsp_err_d   = ~written_q[rd_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            written_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            written_q   <= written_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Randomised bench for mem_ctrl_fsm at read latencies 2, 1 and 15, checked
// against a transaction-level memory/written model.
module tb_mem_ctrl_fsm;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned DEPTH  = 8;
    localparam int unsigned N_DUT  = 3;

    function automatic int unsigned lat_of(input int unsigned d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 15;
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N_DUT-1:0]  rst_n, enable, req_valid, req_ready, req_rb_w;
    logic [N_DUT-1:0]  rsp_valid, rsp_ready, rsp_err, busy;
    logic [ADDR_W-1:0] req_addr  [N_DUT];
    logic [DATA_W-1:0] req_wdata [N_DUT];
    logic [DATA_W-1:0] rsp_rdata [N_DUT];

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        mem_ctrl_fsm #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .READ_LAT (lat_of(g))
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n[g]),
            .enable    (enable[g]),
            .req_valid (req_valid[g]),
            .req_ready (req_ready[g]),
            .req_rb_w  (req_rb_w[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_ready (rsp_ready[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .busy      (busy[g])
        );
    end

    // Reference model: stored value, written-since-reset, and whether the value is known.
    logic [DATA_W-1:0] mem_m   [N_DUT][DEPTH];
    bit                wr_m    [N_DUT][DEPTH];
    bit                known_m [N_DUT][DEPTH];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input int d, input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL lat%0d %s: got %0h expected %0h (t=%0t)",
                     lat_of(d), tag, got, exp, $time);
        end
    endtask

    task automatic apply_reset(input int d);
        rst_n[d]     = 1'b0;
        req_valid[d] = 1'b0;
        rsp_ready[d] = 1'b0;
        #1;
        check(d, "req_ready in reset", 32'(req_ready[d]), 0);
        @(posedge clk);
        #1;
        check(d, "reset rsp_valid", 32'(rsp_valid[d]), 0);
        check(d, "reset busy", 32'(busy[d]), 0);
        check(d, "reset rsp_rdata", 32'(rsp_rdata[d]), 0);
        check(d, "reset rsp_err", 32'(rsp_err[d]), 0);
        rst_n[d] = 1'b1;
        for (int a = 0; a < DEPTH; a++) wr_m[d][a] = 1'b0;
    endtask

    // One full transaction: optional enable-low gating, accept, latency, hold, release.
    task automatic do_op(input int d, input bit rb_w, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input int hold, input int gate);
        int unsigned       lat;
        int                edges;
        logic [DATA_W-1:0] exp_d;
        bit                exp_e;
        bit                chk_d;
        lat          = rb_w ? 1 : lat_of(d);
        rsp_ready[d] = (hold == 0);
        req_rb_w[d]  = rb_w;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        if (gate > 0) begin
            enable[d] = 1'b0;
            repeat (gate) begin
                #1;
                check(d, "gated req_ready", 32'(req_ready[d]), 0);
                @(posedge clk);
                #1;
                check(d, "gated busy", 32'(busy[d]), 0);
            end
            enable[d] = 1'b1;
        end
        #1;
        check(d, "idle req_ready", 32'(req_ready[d]), 1);
        if (rb_w) begin
            mem_m[d][addr]   = wdata;
            wr_m[d][addr]    = 1'b1;
            known_m[d][addr] = 1'b1;
            exp_d = '0;
            exp_e = 1'b0;
            chk_d = 1'b1;
        end else begin
            exp_d = mem_m[d][addr];
            exp_e = !wr_m[d][addr];
            chk_d = known_m[d][addr];
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        edges = 1;
        while (!rsp_valid[d] && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check(d, rb_w ? "write latency" : "read latency", 32'(edges), 32'(lat));
        if (chk_d) check(d, "rsp_rdata", 32'(rsp_rdata[d]), 32'(exp_d));
        check(d, "rsp_err", 32'(rsp_err[d]), 32'(exp_e));
        check(d, "busy in resp", 32'(busy[d]), 1);
        check(d, "req_ready in resp", 32'(req_ready[d]), 0);
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
                check(d, "hold rsp_valid", 32'(rsp_valid[d]), 1);
                if (chk_d) check(d, "hold rsp_rdata", 32'(rsp_rdata[d]), 32'(exp_d));
                check(d, "hold rsp_err", 32'(rsp_err[d]), 32'(exp_e));
                check(d, "hold req_ready", 32'(req_ready[d]), 0);
            end
            rsp_ready[d] = 1'b1;
        end
        @(posedge clk);
        #1;
        check(d, "done rsp_valid", 32'(rsp_valid[d]), 0);
        check(d, "done rsp_rdata", 32'(rsp_rdata[d]), 0);
        check(d, "done busy", 32'(busy[d]), 0);
        check(d, "done req_ready", 32'(req_ready[d]), 1);
        rsp_ready[d] = 1'b0;
    endtask

    // Accept an op, then reset on the following edge: the response must never appear.
    task automatic mid_reset(input int d, input bit rb_w, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata);
        rsp_ready[d] = 1'b1;
        req_rb_w[d]  = rb_w;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_valid[d] = 1'b1;
        #1;
        check(d, "midrst req_ready", 32'(req_ready[d]), 1);
        if (rb_w) begin
            mem_m[d][addr]   = wdata;
            known_m[d][addr] = 1'b1;
        end
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
        apply_reset(d);
        repeat (3) begin
            @(posedge clk);
            #1;
            check(d, "post-reset rsp_valid", 32'(rsp_valid[d]), 0);
        end
    endtask

    // Continuous reads with rsp_ready high: accepts must be READ_LAT+1 cycles apart.
    task automatic throughput(input int d);
        int acc[$];
        int cyc;
        rsp_ready[d] = 1'b1;
        req_rb_w[d]  = 1'b0;
        req_addr[d]  = 3'd7;
        req_valid[d] = 1'b1;
        cyc = 0;
        while (acc.size() < 3 && cyc < 100) begin
            #1;
            if (req_ready[d]) acc.push_back(cyc);
            @(posedge clk);
            #1;
            cyc++;
        end
        req_valid[d] = 1'b0;
        check(d, "b2b accepts", 32'(acc.size()), 3);
        if (acc.size() == 3) begin
            check(d, "b2b period 1", 32'(acc[1] - acc[0]), 32'(lat_of(d) + 1));
            check(d, "b2b period 2", 32'(acc[2] - acc[1]), 32'(lat_of(d) + 1));
        end
        cyc = 0;
        while (busy[d] && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check(d, "b2b drain busy", 32'(busy[d]), 0);
        rsp_ready[d] = 1'b0;
    endtask

    task automatic run(input int d);
        apply_reset(d);
        do_op(d, 1'b0, 3'd4, 8'h00, 0, 0);
        do_op(d, 1'b1, 3'd7, 8'hAB, 0, 0);
        do_op(d, 1'b0, 3'd7, 8'h00, 0, 0);
        do_op(d, 1'b1, 3'd4, 8'h5C, 1, 0);
        do_op(d, 1'b0, 3'd4, 8'h00, 2, 0);
        do_op(d, 1'b0, 3'd7, 8'h00, 5, 0);
        do_op(d, 1'b1, 3'd0, 8'hFF, 0, 3);
        do_op(d, 1'b0, 3'd0, 8'h00, 0, 0);
        mid_reset(d, 1'b0, 3'd7, 8'h00);
        do_op(d, 1'b0, 3'd7, 8'h00, 0, 0);
        mid_reset(d, 1'b1, 3'd3, 8'h11);
        do_op(d, 1'b0, 3'd3, 8'h00, 0, 0);
        throughput(d);
        for (int i = 0; i < 30; i++) begin
            do_op(d, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
        end
    endtask

    initial begin
        rst_n     = '0;
        enable    = '1;
        req_valid = '0;
        req_rb_w  = '0;
        rsp_ready = '0;
        for (int d = 0; d < N_DUT; d++) begin
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            for (int a = 0; a < DEPTH; a++) begin
                mem_m[d][a]   = '0;
                wr_m[d][a]    = 1'b0;
                known_m[d][a] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < N_DUT; d++) run(d);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
